player_motion_ctrl: RTL

PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

---
 rtl/player_motion_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/player_motion_ctrl.sv
// Player motion controller: keyboard-driven walk with x bounds and a fixed-height jump.
// Latency: key decode -> hdir/state one cycle; position steps on the next motion tick.
// No backpressure: inputs are sampled as levels every cycle, outputs are always valid.
module player_motion_ctrl #(
  parameter int TICK_DIV = 80_000,
  parameter int JUMP_H   = 32,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 1000,
  parameter int X_START  = 0,
  parameter int Y_GROUND = 700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  keyCode,
  input  logic        released,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        airborne,
  output logic        facing_left
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [11:0]   XMIN_V    = 12'(X_MIN);
  localparam logic [11:0]   XMAX_V    = 12'(X_MAX);
  localparam logic [11:0]   XSTART_V  = 12'(X_START);
  localparam logic [11:0]   YGROUND_V = 12'(Y_GROUND);
  localparam logic [11:0]   RISE_LAST = 12'(JUMP_H - 1);

  typedef enum logic [1:0] {H_NONE, H_LEFT, H_RIGHT} hdir_t;
  typedef enum logic [1:0] {ST_GROUND, ST_RISE, ST_FALL} vstate_t;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          key_left;
  logic          key_right;
  logic          key_jump;
  hdir_t         hdir;
  vstate_t       state_q;
  vstate_t       state_d;
  logic [11:0]   rise_cnt;
  logic [11:0]   rise_d;
  logic [11:0]   y_d;

  // A key only counts while it is held; released overrides any code.
  assign key_left  = !released && (keyCode == 7'd65 || keyCode == 7'd97);
  assign key_right = !released && (keyCode == 7'd68 || keyCode == 7'd100);
  assign key_jump  = !released && (keyCode == 7'd87 || keyCode == 7'd119 || keyCode == 7'd32);

  assign tick     = (tick_cnt == TICK_LAST);
  assign airborne = (state_q == ST_RISE) || (state_q == ST_FALL);

  // Free-running motion tick divider.
  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // Walk direction latch; opposite key switches directly, release stops walking.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdir        <= H_NONE;
      facing_left <= 1'b0;
    end else if (released) begin
      hdir        <= H_NONE;
    end else if (key_left) begin
      hdir        <= H_LEFT;
      facing_left <= 1'b1;
    end else if (key_right) begin
      hdir        <= H_RIGHT;
      facing_left <= 1'b0;
    end
  end

  // Horizontal step on tick from the pre-update direction, saturating at the bounds.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos <= XSTART_V;
    end else if (tick) begin
      case (hdir)
        H_LEFT:  if (xpos > XMIN_V) xpos <= xpos - 12'd1;
        H_RIGHT: if (xpos < XMAX_V) xpos <= xpos + 12'd1;
        default: xpos <= xpos;
      endcase
    end
  end

  // Vertical FSM state and y/rise counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_GROUND;
      ypos     <= YGROUND_V;
      rise_cnt <= '0;
    end else begin
      state_q  <= state_d;
      ypos     <= y_d;
      rise_cnt <= rise_d;
    end
  end

  // Vertical next-state: a jump is accepted only on the ground; the arc runs to completion.
  always_comb begin
    state_d = state_q;
    y_d     = ypos;
    rise_d  = rise_cnt;
    case (state_q)
      ST_GROUND: begin
        if (key_jump) begin
          state_d = ST_RISE;
          rise_d  = '0;
        end
      end
      ST_RISE: begin
        if (tick) begin
          y_d    = ypos - 12'd1;
          rise_d = rise_cnt + 12'd1;
          if (rise_cnt == RISE_LAST) state_d = ST_FALL;
        end
      end
      ST_FALL: begin
        if (tick) begin
          y_d = ypos + 12'd1;
          if ((ypos + 12'd1) == YGROUND_V) state_d = ST_GROUND;
        end
      end
      default: state_d = ST_GROUND;
    endcase
  end

endmodule
